// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : field widths and the ID/EX payload record shared by the pipeline
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int DATA_W      = 32;
    localparam int ALU_OP_W    = 4;
    localparam int REG_IDX_W   = 5;
    localparam int IMM_W       = 16;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0]    reg_a;
        logic [DATA_W-1:0]    reg_b;
        logic [IMM_W-1:0]     immediate;
        logic                 alu_src;
        logic [ALU_OP_W-1:0]  alu_op;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
    } id_ex_payload_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_slot.sv
`default_nettype none
// ============================================================================
// id_ex_slot : one payload register plus valid bit with load / clear controls
// Revision   : 1.0
// ============================================================================
module id_ex_slot
    import pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           clear,
    input  id_ex_payload_t d,
    output logic           valid,
    output id_ex_payload_t q
);

    // Clear drops only the valid bit; the payload keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// id_ex_pipe_reg : ID/EX valid/ready pipeline register with a one-beat skid
//                  slot. Optional stall counter via ID_EX_STALL_CNT_EN.
// Revision       : 1.0
// ============================================================================
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_reg_a,
    input  logic [DATA_WIDTH-1:0] in_reg_b,
    input  logic [IMM_W-1:0]      in_immediate,
    input  logic                  in_alu_src,
    input  logic [ALU_OP_W-1:0]   in_alu_op,
    input  logic [REG_IDX_W-1:0]  in_rd,
    input  logic                  in_reg_write,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_reg_a,
    output logic [DATA_WIDTH-1:0] out_reg_b,
    output logic [IMM_W-1:0]      out_immediate,
    output logic                  out_select,
    output logic [ALU_OP_W-1:0]   out_alu_op,
    output logic [REG_IDX_W-1:0]  out_rd,
    output logic                  out_reg_write
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    id_ex_payload_t in_payload;
    id_ex_payload_t main_d;
    id_ex_payload_t main_q;
    id_ex_payload_t skid_q;
    logic           main_valid;
    logic           skid_valid;
    logic           main_load;
    logic           main_clear;
    logic           skid_load;
    logic           skid_clear;
    logic           accept;
    logic           consume;

    assign in_payload.reg_a     = in_reg_a;
    assign in_payload.reg_b     = in_reg_b;
    assign in_payload.immediate = in_immediate;
    assign in_payload.alu_src   = in_alu_src;
    assign in_payload.alu_op    = in_alu_op;
    assign in_payload.rd        = in_rd;
    assign in_payload.reg_write = in_reg_write;

    // Registered ready: depends only on skid occupancy, never on out_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = main_valid && out_ready;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_payload;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_valid) begin
            main_load = accept;
        end else if (consume) begin
            if (skid_valid) begin
                main_load  = 1'b1;
                main_d     = skid_q;
                skid_clear = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else begin
            skid_load = accept;
        end
    end

    id_ex_slot u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    id_ex_slot u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign out_valid     = main_valid;
    assign out_reg_a     = main_q.reg_a;
    assign out_reg_b     = main_q.reg_b;
    assign out_immediate = main_q.immediate;
    assign out_select    = main_q.alu_src;
    assign out_alu_op    = main_q.alu_op;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write && main_valid;

`ifdef ID_EX_STALL_CNT_EN
    // Saturating count of cycles EX holds off a valid beat; flush leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (main_valid && !out_ready && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// tb_id_ex_pipe_reg : directed plus randomized checks against a queue model
// Revision          : 1.0
// ============================================================================
module tb_id_ex_pipe_reg;
    import pipe_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_reg_a = '0;
    logic [DATA_W-1:0]    in_reg_b = '0;
    logic [IMM_W-1:0]     in_immediate = '0;
    logic                 in_alu_src = 1'b0;
    logic [ALU_OP_W-1:0]  in_alu_op = '0;
    logic [REG_IDX_W-1:0] in_rd = '0;
    logic                 in_reg_write = 1'b0;
    logic                 flush = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DATA_W-1:0]    out_reg_a;
    logic [DATA_W-1:0]    out_reg_b;
    logic [IMM_W-1:0]     out_immediate;
    logic                 out_select;
    logic [ALU_OP_W-1:0]  out_alu_op;
    logic [REG_IDX_W-1:0] out_rd;
    logic                 out_reg_write;
`ifdef ID_EX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_count;
`endif

    id_ex_pipe_reg #(.DATA_WIDTH(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_a      (in_reg_a),
        .in_reg_b      (in_reg_b),
        .in_immediate  (in_immediate),
        .in_alu_src    (in_alu_src),
        .in_alu_op     (in_alu_op),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_reg_a     (out_reg_a),
        .out_reg_b     (out_reg_b),
        .out_immediate (out_immediate),
        .out_select    (out_select),
        .out_alu_op    (out_alu_op),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: beats held by the stage in FIFO order (at most two).
    id_ex_payload_t model_q[$];
    id_ex_payload_t last_shown = '0;
    int             accepted   = 0;
    int             consumed   = 0;
    int             stalls     = 0;

    task automatic check_eq(input string tag, input logic [127:0] observed,
                            input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic id_ex_payload_t rand_beat();
        id_ex_payload_t p;
        p.reg_a     = $urandom;
        p.reg_b     = $urandom;
        p.immediate = IMM_W'($urandom);
        p.alu_src   = 1'($urandom);
        p.alu_op    = ALU_OP_W'($urandom);
        p.rd        = REG_IDX_W'($urandom);
        p.reg_write = 1'($urandom);
        return p;
    endfunction

    function automatic id_ex_payload_t beat_a(input int val);
        id_ex_payload_t p = '0;
        p.reg_a     = DATA_W'(val);
        p.reg_write = 1'b1;
        return p;
    endfunction

    task automatic compare_all();
        id_ex_payload_t e;
        e = (model_q.size() > 0) ? model_q[0] : last_shown;
        check_eq("out_valid", 128'(out_valid), 128'(model_q.size() > 0));
        check_eq("in_ready", 128'(in_ready), 128'(model_q.size() < 2));
        check_eq("payload",
                 128'({out_reg_a, out_reg_b, out_immediate, out_select, out_alu_op, out_rd}),
                 128'({e.reg_a, e.reg_b, e.immediate, e.alu_src, e.alu_op, e.rd}));
        check_eq("out_reg_write", 128'(out_reg_write),
                 128'((model_q.size() > 0) && e.reg_write));
`ifdef ID_EX_STALL_CNT_EN
        check_eq("stall_count", 128'(stall_count), 128'(stalls));
`endif
    endtask

    // One clock: drive at negedge, advance model at posedge, compare after it.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic rdy, input id_ex_payload_t p);
        int pre;
        @(negedge clk);
        rst          = r;
        flush        = f;
        in_valid     = v;
        out_ready    = rdy;
        in_reg_a     = p.reg_a;
        in_reg_b     = p.reg_b;
        in_immediate = p.immediate;
        in_alu_src   = p.alu_src;
        in_alu_op    = p.alu_op;
        in_rd        = p.rd;
        in_reg_write = p.reg_write;
        @(posedge clk);
        pre = model_q.size();
        if (r) begin
            model_q.delete();
            last_shown = '0;
            stalls     = 0;
        end else begin
            if (pre > 0 && !rdy && stalls != 16'hFFFF) stalls++;
            if (pre > 0 && rdy) consumed++;
            if (f) begin
                model_q.delete();
            end else begin
                if (pre > 0 && rdy) void'(model_q.pop_front());
                if (v && pre < 2) begin
                    model_q.push_back(p);
                    accepted++;
                end
            end
        end
        if (model_q.size() > 0) last_shown = model_q[0];
        #1;
        compare_all();
    endtask

    initial begin
        id_ex_payload_t p;
        int             cyc;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_eq("reset_out_valid", 128'(out_valid), 128'(0));
        check_eq("reset_in_ready", 128'(in_ready), 128'(1));
        check_eq("reset_reg_a", 128'(out_reg_a), 128'(0));

        // Pass-through
        p = '0;
        p.reg_b = 94035; p.immediate = 4096; p.alu_src = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, p);
        check_eq("pt_valid", 128'(out_valid), 128'(1));
        check_eq("pt_imm", 128'(out_immediate), 128'(4096));
        check_eq("pt_select", 128'(out_select), 128'(1));
        check_eq("pt_reg_b", 128'(out_reg_b), 128'(94035));
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Backpressure: A to MAIN, B to SKID, C held upstream
        step(1'b0, 1'b0, 1'b1, 1'b0, beat_a(1));
        step(1'b0, 1'b0, 1'b1, 1'b0, beat_a(2));
        check_eq("bp_in_ready", 128'(in_ready), 128'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0, beat_a(3));
        check_eq("bp_hold_a", 128'(out_reg_a), 128'(1));
        step(1'b0, 1'b0, 1'b1, 1'b1, beat_a(3));
        check_eq("bp_then_b", 128'(out_reg_a), 128'(2));
        step(1'b0, 1'b0, 1'b1, 1'b1, beat_a(3));
        check_eq("bp_then_c", 128'(out_reg_a), 128'(3));
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_eq("bp_drained", 128'(out_valid), 128'(0));

        // Flush with full SKID and an offered beat
        step(1'b0, 1'b0, 1'b1, 1'b0, beat_a(7));
        step(1'b0, 1'b0, 1'b1, 1'b0, beat_a(8));
        step(1'b0, 1'b1, 1'b1, 1'b0, beat_a(9));
        check_eq("flush_valid", 128'(out_valid), 128'(0));
        check_eq("flush_in_ready", 128'(in_ready), 128'(1));
        check_eq("flush_reg_write", 128'(out_reg_write), 128'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_eq("flush_no_ghost", 128'(out_valid), 128'(0));

        // Random stream of 100 beats with random backpressure
        accepted = 0;
        consumed = 0;
        cyc      = 0;
        while (accepted < 100 && cyc < 2000) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), rand_beat());
            cyc++;
        end
        check_eq("stream_budget", 128'(accepted), 128'(100));
        cyc = 0;
        while (model_q.size() > 0 && cyc < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, '0);
            cyc++;
        end
        check_eq("stream_drained", 128'(out_valid), 128'(0));
        check_eq("stream_consumed", 128'(consumed), 128'(100));

        // Reset mid-transfer drops everything
        step(1'b0, 1'b0, 1'b1, 1'b0, rand_beat());
        step(1'b1, 1'b1, 1'b1, 1'b0, rand_beat());
        check_eq("rst_mid_valid", 128'(out_valid), 128'(0));
        check_eq("rst_mid_reg_b", 128'(out_reg_b), 128'(0));

`ifdef ID_EX_STALL_CNT_EN
        step(1'b0, 1'b0, 1'b1, 1'b0, beat_a(5));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("stall_ten", 128'(stall_count), 128'(10));
        step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check_eq("stall_after_flush", 128'(stall_count), 128'(10));
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_eq("stall_after_rst", 128'(stall_count), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
